// File: rtl/ez_pipe_pkg.sv
// Shared RV32I decode definitions for the ez_pipe dual-issue core:
// opcode/funct constants, ALU and immediate-format enums, decode helpers.
package ez_pipe_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef struct packed {
    logic     we;
    logic     uses_rs1;
    logic     uses_rs2;
    logic     is_jal;
    logic     is_jalr;
    logic     is_branch;
    logic     a_pc;
    logic     b_imm;
    alu_op_e  op;
    imm_fmt_e fmt;
  } dec_t;

  function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] ins, input imm_fmt_e fmt);
    logic [XLEN-1:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:   imm = {ins[31:12], 12'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    op = ALU_ADD;
    case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      F3_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // Anything outside the supported subset collapses to an all-zero NOP
  // so it neither writes nor creates a false dependency.
  function automatic dec_t decode(input logic [31:0] ins);
    dec_t       d;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       ok;
    f7 = ins[31:25];
    f3 = ins[14:12];
    d = '0;
    d.op = ALU_ADD;
    d.fmt = IMM_NONE;
    ok = 1'b1;
    case (ins[6:0])
      OPC_LUI: begin
        d.we = 1'b1; d.b_imm = 1'b1; d.op = ALU_PASSB; d.fmt = IMM_U;
      end
      OPC_AUIPC: begin
        d.we = 1'b1; d.a_pc = 1'b1; d.b_imm = 1'b1; d.fmt = IMM_U;
      end
      OPC_JAL: begin
        d.we = 1'b1; d.is_jal = 1'b1; d.fmt = IMM_J;
      end
      OPC_JALR: begin
        d.we = 1'b1; d.is_jalr = 1'b1; d.uses_rs1 = 1'b1; d.fmt = IMM_I;
        ok = (f3 == 3'd0);
      end
      OPC_BRANCH: begin
        d.is_branch = 1'b1; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1; d.fmt = IMM_B;
        ok = (f3 != 3'd2) && (f3 != 3'd3);
      end
      OPC_OPIMM: begin
        d.we = 1'b1; d.uses_rs1 = 1'b1; d.b_imm = 1'b1; d.fmt = IMM_I;
        if (f3 == F3_SLL) ok = (f7 == F7_BASE);
        else if (f3 == F3_SR) ok = (f7 == F7_BASE) || (f7 == F7_ALT);
        d.op = alu_from_f3(f3, (f3 == F3_SR) && ins[30]);
      end
      OPC_OP: begin
        d.we = 1'b1; d.uses_rs1 = 1'b1; d.uses_rs2 = 1'b1;
        ok = (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
        d.op = alu_from_f3(f3, ins[30]);
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      d = '0;
      d.op = ALU_ADD;
      d.fmt = IMM_NONE;
    end
    return d;
  endfunction

endpackage

// File: rtl/ez_pipe_alu.sv
// Per-slot RV32I integer ALU with a separate branch comparator.
module ez_pipe_alu
  import ez_pipe_pkg::*;
#(
  parameter int DATA_W = XLEN
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        br_f3,
  output logic [DATA_W-1:0] result,
  output logic              br_taken
);

  localparam int SH_W = $clog2(DATA_W);

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic        [SH_W-1:0]   shamt;

  assign a_s   = a;
  assign b_s   = b;
  assign shamt = b[SH_W-1:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_SLL:   result = a << shamt;
      ALU_SLT:   result = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU:  result = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_XOR:   result = a ^ b;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = a_s >>> shamt;
      ALU_OR:    result = a | b;
      ALU_AND:   result = a & b;
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (br_f3)
      F3_BEQ:  br_taken = (a == b);
      F3_BNE:  br_taken = (a != b);
      F3_BLT:  br_taken = (a_s < b_s);
      F3_BGE:  br_taken = (a_s >= b_s);
      F3_BLTU: br_taken = (a < b);
      F3_BGEU: br_taken = (a >= b);
      default: br_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ez_pipe.sv
// Two-stage dual-issue RV32I core: fetch a PC/PC+4 pair from a synchronous
// ROM, then decode, execute and write back both slots the following cycle.
module ez_pipe
  import ez_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] ibus_addr1,
  input  logic [31:0] ibus_data1,
  output logic [31:0] ibus_addr2,
  input  logic [31:0] ibus_data2,
  output logic [1:0]  dbg_we,
  output logic [4:0]  dbg_rd1,
  output logic [4:0]  dbg_rd2,
  output logic [31:0] dbg_wd1,
  output logic [31:0] dbg_wd2
);

  logic [XLEN-1:0] pc_p0;
  logic [XLEN-1:0] fpc_p1;
  logic            vld_p1;
  logic [XLEN-1:0] rf [32];

  // ---- stage 0: fetch address pair straight from the PC register
  assign ibus_addr1 = pc_p0;
  assign ibus_addr2 = pc_p0 + 32'd4;

  // ---- stage 1: ROM data for fpc_p1 arrives; decode/execute both slots
  logic [31:0]     ins     [2];
  logic [XLEN-1:0] ipc     [2];
  dec_t            dec     [2];
  logic [4:0]      rd      [2];
  logic [4:0]      rs1     [2];
  logic [4:0]      rs2     [2];
  logic [XLEN-1:0] imm     [2];
  logic [XLEN-1:0] rs1v    [2];
  logic [XLEN-1:0] rs2v    [2];
  logic [XLEN-1:0] opa     [2];
  logic [XLEN-1:0] opb     [2];
  logic [XLEN-1:0] alu_res [2];
  logic [XLEN-1:0] wdata   [2];
  logic [XLEN-1:0] target  [2];
  logic            br_tk   [2];
  logic            redir   [2];

  assign ins[0] = ibus_data1;
  assign ins[1] = ibus_data2;
  assign ipc[0] = fpc_p1;
  assign ipc[1] = fpc_p1 + 32'd4;

  for (genvar s = 0; s < 2; s++) begin : g_slot
    assign dec[s]  = decode(ins[s]);
    assign rd[s]   = ins[s][11:7];
    assign rs1[s]  = ins[s][19:15];
    assign rs2[s]  = ins[s][24:20];
    assign imm[s]  = imm_gen(ins[s], dec[s].fmt);
    assign rs1v[s] = (rs1[s] == 5'd0) ? '0 : rf[rs1[s]];
    assign rs2v[s] = (rs2[s] == 5'd0) ? '0 : rf[rs2[s]];
    assign opa[s]  = dec[s].a_pc ? ipc[s] : rs1v[s];
    assign opb[s]  = dec[s].b_imm ? imm[s] : rs2v[s];

    ez_pipe_alu #(.DATA_W(XLEN)) u_alu (
      .op       (dec[s].op),
      .a        (opa[s]),
      .b        (opb[s]),
      .br_f3    (ins[s][14:12]),
      .result   (alu_res[s]),
      .br_taken (br_tk[s])
    );

    assign target[s] = dec[s].is_jalr ? ((rs1v[s] + imm[s]) & ~32'd1) : (ipc[s] + imm[s]);
    assign redir[s]  = dec[s].is_jal | dec[s].is_jalr | (dec[s].is_branch & br_tk[s]);
    assign wdata[s]  = (dec[s].is_jal | dec[s].is_jalr) ? (ipc[s] + 32'd4) : alu_res[s];
  end

  logic            hazard;
  logic [1:0]      wr;
  logic [XLEN-1:0] pc_nxt;
  logic            vld_nxt;

  // Priority: slot1 redirect squashes slot2; a RAW stall replays slot2 from
  // FPC+4; otherwise both retire and slot2 may redirect.
  always_comb begin
    hazard  = dec[0].we && (rd[0] != 5'd0) &&
              ((dec[1].uses_rs1 && (rs1[1] == rd[0])) ||
               (dec[1].uses_rs2 && (rs2[1] == rd[0])));
    wr      = 2'b00;
    pc_nxt  = pc_p0 + 32'd8;
    vld_nxt = 1'b1;
    if (vld_p1) begin
      wr[0] = dec[0].we && (rd[0] != 5'd0);
      if (redir[0]) begin
        pc_nxt  = target[0];
        vld_nxt = 1'b0;
      end else if (hazard) begin
        pc_nxt  = fpc_p1 + 32'd4;
        vld_nxt = 1'b0;
      end else begin
        wr[1] = dec[1].we && (rd[1] != 5'd0);
        if (redir[1]) begin
          pc_nxt  = target[1];
          vld_nxt = 1'b0;
        end
      end
    end
  end

  assign dbg_we  = reset ? 2'b00 : wr;
  assign dbg_rd1 = rd[0];
  assign dbg_rd2 = rd[1];
  assign dbg_wd1 = wdata[0];
  assign dbg_wd2 = wdata[1];

  // ---- stage 1 -> register file / next fetch; slot2 written last so it wins
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0  <= RESET_PC;
      fpc_p1 <= RESET_PC;
      vld_p1 <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      pc_p0  <= pc_nxt;
      fpc_p1 <= pc_p0;
      vld_p1 <= vld_nxt;
      if (wr[0]) rf[rd[0]] <= wdata[0];
      if (wr[1]) rf[rd[1]] <= wdata[1];
    end
  end

endmodule

// File: tb/tb_ez_pipe.sv
// Directed testbench for ez_pipe: a synchronous dual-port ROM model feeds
// hand-assembled programs; retirement is observed on the dbg_* ports.
module tb_ez_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ibus_addr1, ibus_addr2;
  logic [31:0] ibus_data1 = NOP;
  logic [31:0] ibus_data2 = NOP;
  logic [1:0]  dbg_we;
  logic [4:0]  dbg_rd1, dbg_rd2;
  logic [31:0] dbg_wd1, dbg_wd2;
  logic [31:0] rom [64];
  int          checks = 0;
  int          errors = 0;

  ez_pipe #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .ibus_addr1 (ibus_addr1),
    .ibus_data1 (ibus_data1),
    .ibus_addr2 (ibus_addr2),
    .ibus_data2 (ibus_data2),
    .dbg_we     (dbg_we),
    .dbg_rd1    (dbg_rd1),
    .dbg_rd2    (dbg_rd2),
    .dbg_wd1    (dbg_wd1),
    .dbg_wd2    (dbg_wd2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ibus_data1 <= rom[ibus_addr1[7:2]];
    ibus_data2 <= rom[ibus_addr2[7:2]];
  end

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_op(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'h37};
  endfunction

  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] enc_br(input logic [2:0] f3, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  task automatic load_nops();
    for (int i = 0; i < 64; i++) rom[i] = NOP;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_a;
    load_nops();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (ibus_addr1 !== 32'h0) begin errors++; $display("FAIL rst_addr_in_reset: got %h expected %h", ibus_addr1, 32'h0); end
    checks++; if (dbg_we !== 2'b00) begin errors++; $display("FAIL rst_we_in_reset: got %b expected %b", dbg_we, 2'b00); end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp_a = 32'(8 * k);
      checks++; if (ibus_addr1 !== exp_a) begin errors++; $display("FAIL rst_addr1[%0d]: got %h expected %h", k, ibus_addr1, exp_a); end
      checks++; if (ibus_addr2 !== exp_a + 32'd4) begin errors++; $display("FAIL rst_addr2[%0d]: got %h expected %h", k, ibus_addr2, exp_a + 32'd4); end
      checks++; if (dbg_we !== 2'b00) begin errors++; $display("FAIL rst_nop_we[%0d]: got %b expected %b", k, dbg_we, 2'b00); end
    end
  endtask

  task automatic test_dual_issue();
    load_nops();
    rom[0] = enc_addi(5'd1, 5'd0, 12'd5);
    rom[1] = enc_addi(5'd2, 5'd0, 12'd7);
    apply_reset();
    @(negedge clk);
    checks++; if (dbg_we !== 2'b00) begin errors++; $display("FAIL dual_c0_we: got %b expected %b", dbg_we, 2'b00); end
    @(negedge clk);
    checks++; if (dbg_we !== 2'b11) begin errors++; $display("FAIL dual_we: got %b expected %b", dbg_we, 2'b11); end
    checks++; if (dbg_rd1 !== 5'd1 || dbg_wd1 !== 32'd5) begin errors++; $display("FAIL dual_slot1: got x%0d=%0d expected x1=5", dbg_rd1, dbg_wd1); end
    checks++; if (dbg_rd2 !== 5'd2 || dbg_wd2 !== 32'd7) begin errors++; $display("FAIL dual_slot2: got x%0d=%0d expected x2=7", dbg_rd2, dbg_wd2); end
    checks++; if (ibus_addr1 !== 32'd8) begin errors++; $display("FAIL dual_addr: got %h expected %h", ibus_addr1, 32'd8); end
  endtask

  task automatic test_hazard();
    load_nops();
    rom[0] = enc_addi(5'd1, 5'd0, 12'd5);
    rom[1] = enc_addi(5'd2, 5'd1, 12'd1);
    rom[2] = enc_addi(5'd7, 5'd0, 12'd9);
    apply_reset();
    @(negedge clk);
    checks++; if (ibus_addr1 !== 32'd0) begin errors++; $display("FAIL haz_addr_c0: got %h expected %h", ibus_addr1, 32'd0); end
    @(negedge clk);
    checks++; if (ibus_addr1 !== 32'd8) begin errors++; $display("FAIL haz_addr_c1: got %h expected %h", ibus_addr1, 32'd8); end
    checks++; if (dbg_we !== 2'b01) begin errors++; $display("FAIL haz_we_c1: got %b expected %b", dbg_we, 2'b01); end
    checks++; if (dbg_rd1 !== 5'd1 || dbg_wd1 !== 32'd5) begin errors++; $display("FAIL haz_x1: got x%0d=%0d expected x1=5", dbg_rd1, dbg_wd1); end
    @(negedge clk);
    checks++; if (ibus_addr1 !== 32'd4) begin errors++; $display("FAIL haz_addr_c2: got %h expected %h", ibus_addr1, 32'd4); end
    checks++; if (dbg_we !== 2'b00) begin errors++; $display("FAIL haz_discard_we: got %b expected %b", dbg_we, 2'b00); end
    @(negedge clk);
    checks++; if (ibus_addr1 !== 32'd12) begin errors++; $display("FAIL haz_addr_c3: got %h expected %h", ibus_addr1, 32'd12); end
    checks++; if (dbg_we !== 2'b11) begin errors++; $display("FAIL haz_we_c3: got %b expected %b", dbg_we, 2'b11); end
    checks++; if (dbg_rd1 !== 5'd2 || dbg_wd1 !== 32'd6) begin errors++; $display("FAIL haz_x2: got x%0d=%0d expected x2=6", dbg_rd1, dbg_wd1); end
    checks++; if (dbg_rd2 !== 5'd7 || dbg_wd2 !== 32'd9) begin errors++; $display("FAIL haz_x7: got x%0d=%0d expected x7=9", dbg_rd2, dbg_wd2); end
  endtask

  task automatic test_jal();
    load_nops();
    rom[0] = enc_jal(5'd1, 21'd16);
    rom[1] = enc_addi(5'd2, 5'd0, 12'd3);
    rom[4] = enc_addi(5'd4, 5'd0, 12'd4);
    rom[5] = enc_addi(5'd5, 5'd0, 12'd5);
    apply_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (dbg_we !== 2'b01) begin errors++; $display("FAIL jal_we: got %b expected %b", dbg_we, 2'b01); end
    checks++; if (dbg_rd1 !== 5'd1 || dbg_wd1 !== 32'd4) begin errors++; $display("FAIL jal_link: got x%0d=%0d expected x1=4", dbg_rd1, dbg_wd1); end
    @(negedge clk);
    checks++; if (ibus_addr1 !== 32'd16) begin errors++; $display("FAIL jal_target: got %h expected %h", ibus_addr1, 32'd16); end
    checks++; if (dbg_we !== 2'b00) begin errors++; $display("FAIL jal_bubble_we: got %b expected %b", dbg_we, 2'b00); end
    @(negedge clk);
    checks++; if (dbg_we !== 2'b11) begin errors++; $display("FAIL jal_dest_we: got %b expected %b", dbg_we, 2'b11); end
    checks++; if (dbg_wd1 !== 32'd4 || dbg_wd2 !== 32'd5) begin errors++; $display("FAIL jal_dest_wd: got %0d/%0d expected 4/5", dbg_wd1, dbg_wd2); end
  endtask

  task automatic test_branch();
    load_nops();
    rom[0] = enc_addi(5'd3, 5'd0, 12'd1);
    rom[1] = enc_br(3'd0, 5'd0, 5'd0, 13'd12);
    rom[2] = enc_addi(5'd6, 5'd0, 12'd6);
    rom[4] = enc_addi(5'd4, 5'd0, 12'd4);
    apply_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (dbg_we !== 2'b01) begin errors++; $display("FAIL beq_we: got %b expected %b", dbg_we, 2'b01); end
    checks++; if (dbg_rd1 !== 5'd3 || dbg_wd1 !== 32'd1) begin errors++; $display("FAIL beq_x3: got x%0d=%0d expected x3=1", dbg_rd1, dbg_wd1); end
    @(negedge clk);
    checks++; if (ibus_addr1 !== 32'd16) begin errors++; $display("FAIL beq_target: got %h expected %h", ibus_addr1, 32'd16); end
    checks++; if (dbg_we !== 2'b00) begin errors++; $display("FAIL beq_bubble_we: got %b expected %b", dbg_we, 2'b00); end
    @(negedge clk);
    checks++; if (dbg_we !== 2'b01 || dbg_wd1 !== 32'd4) begin errors++; $display("FAIL beq_dest: got we=%b wd=%0d expected we=01 wd=4", dbg_we, dbg_wd1); end

    rom[1] = enc_br(3'd1, 5'd0, 5'd0, 13'd12);
    apply_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (dbg_we !== 2'b01) begin errors++; $display("FAIL bne_we: got %b expected %b", dbg_we, 2'b01); end
    @(negedge clk);
    checks++; if (ibus_addr1 !== 32'd16) begin errors++; $display("FAIL bne_addr: got %h expected %h", ibus_addr1, 32'd16); end
    checks++; if (dbg_we !== 2'b01 || dbg_rd1 !== 5'd6 || dbg_wd1 !== 32'd6) begin errors++; $display("FAIL bne_fallthrough: got we=%b x%0d=%0d expected we=01 x6=6", dbg_we, dbg_rd1, dbg_wd1); end
  endtask

  task automatic test_same_rd();
    load_nops();
    rom[0] = enc_addi(5'd1, 5'd0, 12'd5);
    rom[1] = enc_addi(5'd1, 5'd0, 12'd9);
    rom[2] = enc_addi(5'd2, 5'd1, 12'd0);
    apply_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (dbg_we !== 2'b11) begin errors++; $display("FAIL samerd_we: got %b expected %b", dbg_we, 2'b11); end
    @(negedge clk);
    checks++; if (dbg_wd1 !== 32'd9) begin errors++; $display("FAIL samerd_winner: got %0d expected %0d", dbg_wd1, 9); end
  endtask

  task automatic test_alu();
    load_nops();
    rom[0] = enc_addi(5'd1, 5'd0, 12'hFFB);
    rom[1] = enc_addi(5'd2, 5'd0, 12'd3);
    rom[2] = enc_op(7'h00, 3'd2, 5'd3, 5'd1, 5'd2);
    rom[3] = enc_op(7'h00, 3'd3, 5'd4, 5'd1, 5'd2);
    rom[4] = enc_op(7'h20, 3'd5, 5'd5, 5'd1, 5'd2);
    rom[5] = enc_op(7'h20, 3'd0, 5'd6, 5'd2, 5'd1);
    rom[6] = enc_lui(5'd7, 20'h12345);
    rom[7] = enc_op(7'h00, 3'd1, 5'd8, 5'd2, 5'd2);
    rom[8] = 32'h0000_2483;
    apply_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (dbg_wd1 !== 32'hFFFF_FFFB || dbg_wd2 !== 32'd3) begin errors++; $display("FAIL alu_addi: got %h/%h expected fffffffb/00000003", dbg_wd1, dbg_wd2); end
    @(negedge clk);
    checks++; if (dbg_we !== 2'b11) begin errors++; $display("FAIL alu_slt_we: got %b expected %b", dbg_we, 2'b11); end
    checks++; if (dbg_wd1 !== 32'd1) begin errors++; $display("FAIL alu_slt: got %h expected %h", dbg_wd1, 32'd1); end
    checks++; if (dbg_wd2 !== 32'd0) begin errors++; $display("FAIL alu_sltu: got %h expected %h", dbg_wd2, 32'd0); end
    @(negedge clk);
    checks++; if (dbg_wd1 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL alu_sra: got %h expected %h", dbg_wd1, 32'hFFFF_FFFF); end
    checks++; if (dbg_wd2 !== 32'd8) begin errors++; $display("FAIL alu_sub: got %h expected %h", dbg_wd2, 32'd8); end
    @(negedge clk);
    checks++; if (dbg_wd1 !== 32'h1234_5000) begin errors++; $display("FAIL alu_lui: got %h expected %h", dbg_wd1, 32'h1234_5000); end
    checks++; if (dbg_wd2 !== 32'd24) begin errors++; $display("FAIL alu_sll: got %h expected %h", dbg_wd2, 32'd24); end
    @(negedge clk);
    checks++; if (dbg_we !== 2'b00) begin errors++; $display("FAIL alu_load_nop: got %b expected %b", dbg_we, 2'b00); end
  endtask

  task automatic test_reset_in_stall();
    load_nops();
    rom[0] = enc_addi(5'd1, 5'd0, 12'd5);
    rom[1] = enc_addi(5'd2, 5'd1, 12'd1);
    apply_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (dbg_we !== 2'b01 || dbg_wd1 !== 32'd5) begin errors++; $display("FAIL rs_first: got we=%b wd=%0d expected we=01 wd=5", dbg_we, dbg_wd1); end
    @(negedge clk);
    checks++; if (ibus_addr1 !== 32'd4) begin errors++; $display("FAIL rs_stall_addr: got %h expected %h", ibus_addr1, 32'd4); end
    @(posedge clk);
    #1 reset = 1'b1;
    rom[0] = enc_addi(5'd5, 5'd1, 12'd0);
    rom[1] = enc_addi(5'd6, 5'd2, 12'd0);
    @(negedge clk);
    checks++; if (dbg_we !== 2'b00) begin errors++; $display("FAIL rs_suppress_we: got %b expected %b", dbg_we, 2'b00); end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (ibus_addr1 !== 32'd0) begin errors++; $display("FAIL rs_restart_addr: got %h expected %h", ibus_addr1, 32'd0); end
    @(negedge clk);
    checks++; if (dbg_we !== 2'b11) begin errors++; $display("FAIL rs_reread_we: got %b expected %b", dbg_we, 2'b11); end
    checks++; if (dbg_rd1 !== 5'd5 || dbg_wd1 !== 32'd0) begin errors++; $display("FAIL rs_x1_cleared: got x%0d=%0d expected x5=0", dbg_rd1, dbg_wd1); end
    checks++; if (dbg_rd2 !== 5'd6 || dbg_wd2 !== 32'd0) begin errors++; $display("FAIL rs_x2_unwritten: got x%0d=%0d expected x6=0", dbg_rd2, dbg_wd2); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    load_nops();
    test_reset();
    test_dual_issue();
    test_hazard();
    test_jal();
    test_branch();
    test_same_rd();
    test_alu();
    test_reset_in_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
